// File: rtl/decomp_stream_if.sv
// rtl/decomp_stream_if.sv - beat handshake and coefficient/decomposition bundle for decomp_stream
interface decomp_stream_if #(
    parameter int LANES = 4
);
    logic [2:0]          sec_lvl;
    logic [18:0]         bound;
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [23*LANES-1:0] din;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [6*LANES-1:0]  r1;
    logic [20*LANES-1:0] r0;
    logic [LANES-1:0]    r0_ge;
    logic                reject;

    // Decomposer side.
    modport slave (
        input  sec_lvl, bound, in_valid, in_last, din, out_ready,
        output in_ready, out_valid, out_last, r1, r0, r0_ge, reject
    );

    // Producer/consumer side.
    modport master (
        output sec_lvl, bound, in_valid, in_last, din, out_ready,
        input  in_ready, out_valid, out_last, r1, r0, r0_ge, reject
    );
endinterface

// File: rtl/decomp_stream.sv
// rtl/decomp_stream.sv - 3-stage HighBits/LowBits decomposer with per-polynomial |r0| rejection
module decomp_stream #(
    parameter int LANES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    decomp_stream_if.slave bus
);
    localparam logic [22:0] Q        = 23'd8380417;
    localparam int          G2_LO    = 95232;
    localparam int          G2_HI    = 261888;
    localparam logic [19:0] ALPHA_LO = 20'd190464;
    localparam logic [19:0] ALPHA_HI = 20'd523776;

    // Global stall: every stage moves together whenever the output slot is free.
    logic adv;

    // Stage 1: r1 selected by threshold compare, wrap band flagged.
    logic                s1_valid_q;
    logic [20*LANES-1:0] s1_din_q,  s1_din_d;
    logic [6*LANES-1:0]  s1_r1_q,   s1_r1_d;
    logic [LANES-1:0]    s1_wrap_q, s1_wrap_d;
    logic                s1_mode2_q, s1_mode2_d;
    logic [18:0]         s1_bound_q;
    logic                s1_last_q;
    logic [31:0]         lane_din;

    // Stage 2: subtrahend (r1*alpha, or q in the wrap band).
    logic                s2_valid_q;
    logic [20*LANES-1:0] s2_din_q;
    logic [20*LANES-1:0] s2_sub_q, s2_sub_d;
    logic [6*LANES-1:0]  s2_r1_q,  s2_r1_d;
    logic [18:0]         s2_bound_q;
    logic                s2_last_q;

    // Stage 3: r0, |r0| >= bound, output registers and sticky reject.
    logic                s3_valid_q;
    logic [6*LANES-1:0]  s3_r1_q;
    logic [20*LANES-1:0] s3_r0_q, s3_r0_d;
    logic [LANES-1:0]    s3_ge_q, s3_ge_d;
    logic                s3_last_q;
    logic                acc_q;
    logic [19:0]         lane_r0;
    logic [19:0]         lane_mag;

    assign adv          = !s3_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    // r1 is the count of odd multiples of gamma2 strictly below din; only the
    // low 20 bits of din are needed downstream since |r0| < 2^19.
    always_comb begin
        s1_mode2_d = (bus.sec_lvl == 3'd2);
        s1_r1_d    = '0;
        s1_wrap_d  = '0;
        s1_din_d   = '0;
        lane_din   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_din = {9'd0, bus.din[23*i +: 23]};
            s1_din_d[20*i +: 20] = bus.din[23*i +: 20];
            if (s1_mode2_d) begin
                for (int k = 1; k <= 43; k++) begin
                    if (lane_din > 32'((2*k-1)*G2_LO)) s1_r1_d[6*i +: 6] = 6'(k);
                end
                s1_wrap_d[i] = (lane_din >= 32'(8380417 - G2_LO));
            end else begin
                for (int k = 1; k <= 15; k++) begin
                    if (lane_din > 32'((2*k-1)*G2_HI)) s1_r1_d[6*i +: 6] = 6'(k);
                end
                s1_wrap_d[i] = (lane_din >= 32'(8380417 - G2_HI));
            end
        end
    end

    // Subtrahend computed modulo 2^20: r0 always fits in 20 signed bits, so the
    // truncated difference in stage 3 is exact.
    always_comb begin
        s2_sub_d = '0;
        s2_r1_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_wrap_q[i]) begin
                s2_sub_d[20*i +: 20] = Q[19:0];
                s2_r1_d[6*i +: 6]    = 6'd0;
            end else begin
                s2_sub_d[20*i +: 20] = {14'd0, s1_r1_q[6*i +: 6]} * (s1_mode2_q ? ALPHA_LO : ALPHA_HI);
                s2_r1_d[6*i +: 6]    = s1_r1_q[6*i +: 6];
            end
        end
    end

    // r0 subtract and magnitude compare; bubbles never flag a lane.
    always_comb begin
        s3_r0_d  = '0;
        s3_ge_d  = '0;
        lane_r0  = '0;
        lane_mag = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_r0  = s2_din_q[20*i +: 20] - s2_sub_q[20*i +: 20];
            lane_mag = lane_r0[19] ? (20'd0 - lane_r0) : lane_r0;
            s3_r0_d[20*i +: 20] = lane_r0;
            s3_ge_d[i] = s2_valid_q && (lane_mag >= {1'b0, s2_bound_q});
        end
    end

    // Pipeline registers: all stages shift together on adv, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_din_q   <= '0;
            s1_r1_q    <= '0;
            s1_wrap_q  <= '0;
            s1_mode2_q <= 1'b0;
            s1_bound_q <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_din_q   <= '0;
            s2_sub_q   <= '0;
            s2_r1_q    <= '0;
            s2_bound_q <= '0;
            s2_last_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_r1_q    <= '0;
            s3_r0_q    <= '0;
            s3_ge_q    <= '0;
            s3_last_q  <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= bus.in_valid;
            s1_din_q   <= s1_din_d;
            s1_r1_q    <= s1_r1_d;
            s1_wrap_q  <= s1_wrap_d;
            s1_mode2_q <= s1_mode2_d;
            s1_bound_q <= bus.bound;
            s1_last_q  <= bus.in_valid && bus.in_last;
            s2_valid_q <= s1_valid_q;
            s2_din_q   <= s1_din_q;
            s2_sub_q   <= s2_sub_d;
            s2_r1_q    <= s2_r1_d;
            s2_bound_q <= s1_bound_q;
            s2_last_q  <= s1_last_q;
            s3_valid_q <= s2_valid_q;
            s3_r1_q    <= s2_r1_q;
            s3_r0_q    <= s3_r0_d;
            s3_ge_q    <= s3_ge_d;
            s3_last_q  <= s2_last_q;
        end
    end

    // Sticky per-polynomial reject: collects accepted non-last beats, cleared by the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else if (s3_valid_q && bus.out_ready) begin
            acc_q <= s3_last_q ? 1'b0 : (acc_q | (|s3_ge_q));
        end
    end

    assign bus.out_valid = s3_valid_q;
    assign bus.out_last  = s3_last_q;
    assign bus.r1        = s3_r1_q;
    assign bus.r0        = s3_r0_q;
    assign bus.r0_ge     = s3_ge_q;
    assign bus.reject    = acc_q | (|s3_ge_q);
endmodule

// File: doc/decomp_stream.md
DECOMP_STREAM -- requirements
Module: decomp_stream

Interface
REQ-001 SHALL have parameter LANES, default 4: number of 23-bit coefficients processed per beat (1..8).
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port sec_lvl, input, 3: security level, sampled per beat with in_valid.
REQ-005 SHALL have port bound, input, 19: unsigned |r0| rejection bound, sampled per beat.
REQ-006 SHALL have port in_valid, input, 1: input beat valid.
REQ-007 SHALL have port in_ready, output, 1: input beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_last, input, 1: marks final beat of a polynomial.
REQ-009 SHALL have port din, input, 23*LANES: coefficients, lane i at bits [23i+22:23i], each in [0, q-1], q = 8380417.
REQ-010 SHALL have port out_valid, output, 1: output beat valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts.
REQ-012 SHALL have port out_last, output, 1: in_last delayed with its beat.
REQ-013 SHALL have port r1, output, 6*LANES: HighBits per lane, unsigned.
REQ-014 SHALL have port r0, output, 20*LANES: LowBits per lane, two's complement.
REQ-015 SHALL have port r0_ge, output, LANES: per lane |r0| >= bound.
REQ-016 SHALL have port reject, output, 1: OR of all r0_ge over the polynomial, meaningful only with out_last.

Function
REQ-017 SHALL use gamma2 = 95232, alpha = 190464, r1 range 0..43 when sec_lvl == 2; otherwise gamma2 = 261888, alpha = 523776, r1 range 0..15.
REQ-018 SHALL compute r1 = k for din in [(2k-1)*gamma2+1, (2k+1)*gamma2], r1 = 0 for din <= gamma2, and r0 = din - r1*alpha.
REQ-019 SHALL, for din >= q - gamma2 (wrap band), output r1 = 0 and r0 = din - q (range -gamma2..-1).
REQ-020 SHALL output r0 in [-gamma2, gamma2] for all legal din; r1 high bits unused by the mode SHALL be 0.
REQ-021 SHALL be a 3-stage pipeline: S1 threshold compare / r1 select, S2 r1*alpha product and wrap select, S3 r0 subtract, abs-compare and reject accumulate; latency exactly 3 cycles with no stall.
REQ-022 SHALL carry sec_lvl, bound, and last per beat through the pipeline; mode changes between consecutive beats SHALL be honoured beat by beat.
REQ-023 SHALL advance all stages when adv = !out_valid || out_ready; in_ready = adv (global stall, no bubble collapse).
REQ-024 SHALL hold r1, r0, r0_ge, out_last, and reject stable while out_valid && !out_ready.
REQ-025 SHALL propagate empty stages as bubbles; out_valid SHALL be the S3 valid bit.
REQ-026 SHALL keep a sticky accumulator acc, ORed with |r0_ge| on each accepted non-last output beat.
REQ-027 SHALL drive reject = acc | (|r0_ge|) combinationally from S3, and clear acc to 0 when an out_last beat is accepted.
REQ-028 SHALL sustain one beat per cycle when out_ready stays high.
REQ-029 SHALL treat din >= q as a caller error; outputs are unspecified but SHALL NOT hang the handshake.

Reset
REQ-030 SHALL, while rst_n == 0, clear all stage valid bits and acc, and drive out_valid = 0, out_last = 0, r1 = 0, r0 = 0, r0_ge = 0, reject = 0, in_ready = 1.
REQ-031 SHALL discard in-flight beats and any partial reject state on reset mid-polynomial; the first post-reset beat SHALL start a new polynomial.

Verification
REQ-032 SHALL cover sec_lvl=2 boundaries: din 95232 -> r1=0, r0=95232; 95233 -> r1=1, r0=-95231; 8285184 -> r1=43, r0=95232; 8285185 -> r1=0, r0=-95232.
REQ-033 SHALL cover sec_lvl=3 boundaries: din 261888 -> r1=0, r0=261888; 8118528 -> r1=15, r0=261888; 8118529 -> r1=0, r0=-261888; 0 -> 0, 0.
REQ-034 SHALL cover backpressure: 6 beats back-to-back with out_ready low for cycles 4-8 -> in_ready low exactly when out_valid && !out_ready, all 6 outputs in order, none duplicated, values stable while stalled.
REQ-035 SHALL cover reject: bound=90000, sec_lvl=2, 3-beat polynomial with one lane r0=-90000 in beat 2 -> r0_ge set on that lane only, reject=1 on beat 3; next clean polynomial -> reject=0.
REQ-036 SHALL cover a mode switch between adjacent beats (sec_lvl 2 then 5, din 300000 both) -> r1=2, r0=-80928, then r1=1, r0=-223776.
REQ-037 SHALL cover reset mid-stream: rst_n low for 1 cycle with 2 beats in flight and acc=1 -> out_valid=0 next edge, following polynomial reject reflects only its own beats.
